// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds FSM state encoding and register-file address helpers.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MC_ISSUE = 2'd1,
    MC_BUSY  = 2'd2
  } state_e;

  // A source only counts if it is read and is not the hardwired zero reg.
  function automatic logic src_live(
    input logic                  used,
    input logic [REG_ADDR_W-1:0] src
  );
    return used && (src != REG_ZERO);
  endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// RAW hazard comparator between ID sources and EXE/MEM destinations.
// With forwarding only an EXE load can still cause a stall.
module pipe_hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter bit FORWARD_EN = 1'b0
) (
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  input  logic                  rs_used,
  input  logic                  rt_used,
  input  logic                  exe_rf_wena,
  input  logic [REG_ADDR_W-1:0] exe_rf_waddr,
  input  logic                  exe_is_load,
  input  logic                  mem_rf_wena,
  input  logic [REG_ADDR_W-1:0] mem_rf_waddr,
  output logic                  hazard
);

  logic exe_ok;
  logic mem_ok;
  logic rs_hit;
  logic rt_hit;

  // Which in-flight writers can still cause a stall
  assign exe_ok = exe_rf_wena && (FORWARD_EN ? exe_is_load : 1'b1);
  assign mem_ok = mem_rf_wena && !FORWARD_EN;

  // Per-source match against the qualified writers
  assign rs_hit = src_live(rs_used, rs_addr) &&
                  ((exe_ok && (exe_rf_waddr == rs_addr)) ||
                   (mem_ok && (mem_rf_waddr == rs_addr)));
  assign rt_hit = src_live(rt_used, rt_addr) &&
                  ((exe_ok && (exe_rf_waddr == rt_addr)) ||
                   (mem_ok && (mem_rf_waddr == rt_addr)));

  assign hazard = rs_hit || rt_hit;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stage enables, flush/bubble, MC handshake,
// multi-cycle timeout and a saturating stall counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter bit FORWARD_EN = 1'b0,
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs_addr,
  input  logic [REG_ADDR_W-1:0] id_rt_addr,
  input  logic                  id_rs_used,
  input  logic                  id_rt_used,
  input  logic                  id_branch_taken,
  input  logic                  id_mc_start,
  input  logic                  exe_rf_wena,
  input  logic [REG_ADDR_W-1:0] exe_rf_waddr,
  input  logic                  exe_is_load,
  input  logic                  mem_rf_wena,
  input  logic [REG_ADDR_W-1:0] mem_rf_waddr,
  input  logic                  mc_ack,
  input  logic                  mc_done,
  output logic                  pc_wena,
  output logic                  fd_wena,
  output logic                  fd_flush,
  output logic                  de_bubble,
  output logic                  em_wena,
  output logic                  mw_wena,
  output logic                  stall,
  output logic                  mc_req,
  output logic                  mc_timeout,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int TO_W = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MC_TIMEOUT - 1);

  state_e          state;
  state_e          state_nxt;
  logic            run;
  logic [TO_W-1:0] tcnt;
  logic            to_clr;
  logic            to_hit;
  logic            hazard;

  pipe_hazard_detect #(
    .FORWARD_EN(FORWARD_EN)
  ) u_detect (
    .rs_addr     (id_rs_addr),
    .rt_addr     (id_rt_addr),
    .rs_used     (id_rs_used),
    .rt_used     (id_rt_used),
    .exe_rf_wena (exe_rf_wena),
    .exe_rf_waddr(exe_rf_waddr),
    .exe_is_load (exe_is_load),
    .mem_rf_wena (mem_rf_wena),
    .mem_rf_waddr(mem_rf_waddr),
    .hazard      (hazard)
  );

  // Next state and all pipe controls; everything idle until run is set
  always_comb begin
    state_nxt = state;
    pc_wena   = 1'b0;
    fd_wena   = 1'b0;
    fd_flush  = 1'b0;
    de_bubble = 1'b0;
    em_wena   = 1'b0;
    mw_wena   = 1'b0;
    stall     = 1'b0;
    mc_req    = 1'b0;
    to_clr    = 1'b0;
    to_hit    = 1'b0;
    if (run) begin
      em_wena = 1'b1;
      mw_wena = 1'b1;
      unique case (state)
        RUN: begin
          if (hazard) begin
            stall     = 1'b1;
            de_bubble = 1'b1;
          end else if (id_branch_taken) begin
            pc_wena  = 1'b1;
            fd_wena  = 1'b1;
            fd_flush = 1'b1;
          end else if (id_mc_start) begin
            stall     = 1'b1;
            de_bubble = 1'b1;
            to_clr    = 1'b1;
            state_nxt = MC_ISSUE;
          end else begin
            pc_wena = 1'b1;
            fd_wena = 1'b1;
          end
        end
        MC_ISSUE: begin
          mc_req = 1'b1;
          if (mc_ack && mc_done) begin
            pc_wena   = 1'b1;
            fd_wena   = 1'b1;
            state_nxt = RUN;
          end else begin
            stall     = 1'b1;
            de_bubble = 1'b1;
            if (tcnt == TO_LAST) begin
              to_hit    = 1'b1;
              state_nxt = RUN;
            end else if (mc_ack) begin
              state_nxt = MC_BUSY;
            end
          end
        end
        MC_BUSY: begin
          if (mc_done) begin
            pc_wena   = 1'b1;
            fd_wena   = 1'b1;
            state_nxt = RUN;
          end else begin
            stall     = 1'b1;
            de_bubble = 1'b1;
            if (tcnt == TO_LAST) begin
              to_hit    = 1'b1;
              state_nxt = RUN;
            end
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // FSM state and run flop; run rises on the first edge out of reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      run   <= 1'b0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
    end
  end

  // Cycles spent in the multi-cycle states
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt <= '0;
    end else if (to_clr) begin
      tcnt <= '0;
    end else if (state != RUN && state_nxt != RUN) begin
      tcnt <= tcnt + TO_W'(1);
    end
  end

  // Sticky timeout flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mc_timeout <= 1'b0;
    end else if (to_hit) begin
      mc_timeout <= 1'b1;
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (no forwarding / forwarding)
// share stimulus; vector table, directed MC sequences, random vs model.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs_addr;
  logic [4:0] id_rt_addr;
  logic       id_rs_used;
  logic       id_rt_used;
  logic       id_branch_taken;
  logic       id_mc_start;
  logic       exe_rf_wena;
  logic [4:0] exe_rf_waddr;
  logic       exe_is_load;
  logic       mem_rf_wena;
  logic [4:0] mem_rf_waddr;
  logic       mc_ack;
  logic       mc_done;

  logic [1:0]  pc, fd, fl, bb, em, mw, st, rq, tmo;
  logic [31:0] cnt0;
  logic [2:0]  cnt1;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic pc, fd, fl, bb, em, mw, st, rq;
  } exp_t;

  typedef struct {
    int     mode;
    int     age;
    int     tlim;
    bit     tmo;
    bit     run;
    bit     fwd;
    longint cnt;
    longint cmax;
  } mdl_t;

  mdl_t m [2];

  typedef struct {
    logic [4:0] rs, rt, ea, ma;
    bit ru, tu, br, ew, ld, mwe;
    bit st0, fl0, st1, fl1;
  } vec_t;

  vec_t tbl [12];

  pipe_hazard_ctrl #(
    .FORWARD_EN(1'b0), .MC_TIMEOUT(64), .CNT_W(32)
  ) dut0 (
    .clk(clk), .rst(rst),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_branch_taken(id_branch_taken), .id_mc_start(id_mc_start),
    .exe_rf_wena(exe_rf_wena), .exe_rf_waddr(exe_rf_waddr),
    .exe_is_load(exe_is_load),
    .mem_rf_wena(mem_rf_wena), .mem_rf_waddr(mem_rf_waddr),
    .mc_ack(mc_ack), .mc_done(mc_done),
    .pc_wena(pc[0]), .fd_wena(fd[0]), .fd_flush(fl[0]),
    .de_bubble(bb[0]), .em_wena(em[0]), .mw_wena(mw[0]),
    .stall(st[0]), .mc_req(rq[0]), .mc_timeout(tmo[0]),
    .stall_cnt(cnt0)
  );

  pipe_hazard_ctrl #(
    .FORWARD_EN(1'b1), .MC_TIMEOUT(8), .CNT_W(3)
  ) dut1 (
    .clk(clk), .rst(rst),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_branch_taken(id_branch_taken), .id_mc_start(id_mc_start),
    .exe_rf_wena(exe_rf_wena), .exe_rf_waddr(exe_rf_waddr),
    .exe_is_load(exe_is_load),
    .mem_rf_wena(mem_rf_wena), .mem_rf_waddr(mem_rf_waddr),
    .mc_ack(mc_ack), .mc_done(mc_done),
    .pc_wena(pc[1]), .fd_wena(fd[1]), .fd_flush(fl[1]),
    .de_bubble(bb[1]), .em_wena(em[1]), .mw_wena(mw[1]),
    .stall(st[1]), .mc_req(rq[1]), .mc_timeout(tmo[1]),
    .stall_cnt(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] act_of(input int k);
    return {pc[k], fd[k], fl[k], bb[k], em[k], mw[k], st[k], rq[k]};
  endfunction

  function automatic logic [63:0] cnt_of(input int k);
    return (k == 0) ? 64'(cnt0) : 64'(cnt1);
  endfunction

  // RAW rule straight from the hazard definition
  function automatic bit haz(input bit fwd);
    bit h;
    logic [4:0] src [2];
    bit used [2];
    h = 1'b0;
    src[0] = id_rs_addr;  used[0] = id_rs_used;
    src[1] = id_rt_addr;  used[1] = id_rt_used;
    for (int i = 0; i < 2; i++) begin
      if (used[i] && src[i] != 5'd0) begin
        if (fwd)
          h |= exe_is_load && exe_rf_wena && exe_rf_waddr == src[i];
        else
          h |= (exe_rf_wena && exe_rf_waddr == src[i]) ||
               (mem_rf_wena && mem_rf_waddr == src[i]);
      end
    end
    return h;
  endfunction

  // mode: 0 executing, 1 waiting for ack, 2 waiting for result
  function automatic exp_t exp_of(input int k);
    exp_t e;
    bit h;
    e = '0;
    if (!m[k].run) return e;
    e.em = 1'b1;
    e.mw = 1'b1;
    h = haz(m[k].fwd);
    if (m[k].mode == 0) begin
      if (h || (!id_branch_taken && id_mc_start)) begin
        e.st = 1'b1; e.bb = 1'b1;
      end else begin
        e.pc = 1'b1; e.fd = 1'b1; e.fl = id_branch_taken;
      end
    end else begin
      e.rq = (m[k].mode == 1);
      if (mc_done && (m[k].mode == 2 || mc_ack)) begin
        e.pc = 1'b1; e.fd = 1'b1;
      end else begin
        e.st = 1'b1; e.bb = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic advance(input int k, input exp_t e);
    bit h;
    h = haz(m[k].fwd);
    if (!m[k].run) begin
      m[k].run = 1'b1;
      return;
    end
    if (e.st && m[k].cnt < m[k].cmax) m[k].cnt = m[k].cnt + 1;
    if (m[k].mode == 0) begin
      if (!h && !id_branch_taken && id_mc_start) begin
        m[k].mode = 1;
        m[k].age  = 0;
      end
    end else if (mc_done && (m[k].mode == 2 || mc_ack)) begin
      m[k].mode = 0;
    end else if (m[k].age + 1 >= m[k].tlim) begin
      m[k].tmo  = 1'b1;
      m[k].mode = 0;
    end else begin
      if (m[k].mode == 1 && mc_ack) m[k].mode = 2;
      m[k].age = m[k].age + 1;
    end
  endtask

  // Called at a falling edge with inputs already applied
  task automatic cycle();
    exp_t e [2];
    #1;
    for (int k = 0; k < 2; k++) begin
      e[k] = exp_of(k);
      chk($sformatf("ctl%0d", k), 64'(act_of(k)), 64'(e[k]));
      chk($sformatf("tmo%0d", k), 64'(tmo[k]), 64'(m[k].tmo));
      chk($sformatf("cnt%0d", k), cnt_of(k), 64'(m[k].cnt));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) advance(k, e[k]);
    @(negedge clk);
  endtask

  task automatic clr_in();
    id_rs_addr = '0; id_rt_addr = '0;
    id_rs_used = 1'b0; id_rt_used = 1'b0;
    id_branch_taken = 1'b0; id_mc_start = 1'b0;
    exe_rf_wena = 1'b0; exe_rf_waddr = '0; exe_is_load = 1'b0;
    mem_rf_wena = 1'b0; mem_rf_waddr = '0;
    mc_ack = 1'b0; mc_done = 1'b0;
  endtask

  // Async reset pulse starting mid-cycle; outputs must drop at once
  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      m[k].mode = 0; m[k].age = 0; m[k].tmo = 1'b0;
      m[k].cnt = 0;  m[k].run = 1'b0;
      chk($sformatf("rst ctl%0d", k), 64'(act_of(k)), 64'd0);
      chk($sformatf("rst tmo%0d", k), 64'(tmo[k]), 64'd0);
      chk($sformatf("rst cnt%0d", k), cnt_of(k), 64'd0);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  longint base;

  initial begin
    m[0] = '{mode:0, age:0, tlim:64, tmo:0, run:0, fwd:0,
             cnt:0, cmax:64'hFFFF_FFFF};
    m[1] = '{mode:0, age:0, tlim:8, tmo:0, run:0, fwd:1,
             cnt:0, cmax:7};

    tbl[0]  = '{default:0, rs:3, ru:1, ew:1, ea:3, st0:1};
    tbl[1]  = '{default:0, rs:3, ru:1, mwe:1, ma:3, st0:1};
    tbl[2]  = '{default:0, rs:3, ru:1};
    tbl[3]  = '{default:0, rs:3, ru:1, ew:1, ea:3, ld:1, st0:1, st1:1};
    tbl[4]  = '{default:0, rs:3, ru:1, mwe:1, ma:3, st0:1};
    tbl[5]  = '{default:0, rs:0, ru:1, ew:1, ea:0, ld:1};
    tbl[6]  = '{default:0, br:1, fl0:1, fl1:1};
    tbl[7]  = '{default:0, rt:5, tu:1, ew:1, ea:5, br:1, st0:1, fl1:1};
    tbl[8]  = '{default:0, rt:5, tu:1, br:1, fl0:1, fl1:1};
    tbl[9]  = '{default:0, rt:7, tu:0, ew:1, ea:7, ld:1};
    tbl[10] = '{default:0, rt:9, tu:1, mwe:1, ma:9, st0:1};
    tbl[11] = '{default:0, rs:4, ru:1, ew:0, ea:4, ld:1};

    rst = 1'b0;
    clr_in();
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset ctl%0d", k), 64'(act_of(k)), 64'd0);
      chk($sformatf("reset tmo%0d", k), 64'(tmo[k]), 64'd0);
      chk($sformatf("reset cnt%0d", k), cnt_of(k), 64'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    cycle();
    cycle();

    for (int i = 0; i < 12; i++) begin
      clr_in();
      id_rs_addr = tbl[i].rs;   id_rs_used = tbl[i].ru;
      id_rt_addr = tbl[i].rt;   id_rt_used = tbl[i].tu;
      id_branch_taken = tbl[i].br;
      exe_rf_wena = tbl[i].ew;  exe_rf_waddr = tbl[i].ea;
      exe_is_load = tbl[i].ld;
      mem_rf_wena = tbl[i].mwe; mem_rf_waddr = tbl[i].ma;
      #1;
      chk($sformatf("vec%0d stall0", i), 64'(st[0]), 64'(tbl[i].st0));
      chk($sformatf("vec%0d flush0", i), 64'(fl[0]), 64'(tbl[i].fl0));
      chk($sformatf("vec%0d pc0", i), 64'(pc[0]), 64'(!tbl[i].st0));
      chk($sformatf("vec%0d stall1", i), 64'(st[1]), 64'(tbl[i].st1));
      chk($sformatf("vec%0d flush1", i), 64'(fl[1]), 64'(tbl[i].fl1));
      cycle();
    end

    // MC op: ack two cycles after start, result after five busy cycles
    clr_in();
    base = m[0].cnt;
    id_mc_start = 1'b1;
    cycle();
    id_mc_start = 1'b0;
    cycle();
    mc_ack = 1'b1;
    #1 chk("mc req on ack", 64'(rq[0]), 64'd1);
    cycle();
    mc_ack = 1'b0;
    #1 chk("mc req dropped", 64'(rq[0]), 64'd0);
    repeat (5) cycle();
    mc_done = 1'b1;
    #1;
    chk("mc done pc0", 64'(pc[0]), 64'd1);
    chk("mc done bubble0", 64'(bb[0]), 64'd0);
    cycle();
    clr_in();
    #1 chk("mc stall_cnt+8", 64'(cnt0), 64'(base + 8));
    cycle();

    // No ack: short-timeout instance gives up after eight MC cycles
    id_mc_start = 1'b1;
    cycle();
    id_mc_start = 1'b0;
    repeat (7) cycle();
    #1 chk("timeout not yet", 64'(tmo[1]), 64'd0);
    cycle();
    mc_ack = 1'b1;
    mc_done = 1'b1;
    #1;
    chk("timeout flag", 64'(tmo[1]), 64'd1);
    chk("timeout release", 64'(st[1]), 64'd0);
    chk("ack+done pc0", 64'(pc[0]), 64'd1);
    chk("ack+done stall0", 64'(st[0]), 64'd0);
    cycle();
    clr_in();
    cycle();
    #1 chk("timeout sticky", 64'(tmo[1]), 64'd1);

    // Reset while the MC unit is busy
    id_mc_start = 1'b1;
    cycle();
    id_mc_start = 1'b0;
    mc_ack = 1'b1;
    cycle();
    mc_ack = 1'b0;
    cycle();
    cycle();
    do_reset();
    cycle();
    cycle();

    for (int n = 0; n < 1500; n++) begin
      id_rs_addr = 5'($urandom_range(0, 3));
      id_rt_addr = 5'($urandom_range(0, 3));
      id_rs_used = 1'($urandom_range(0, 1));
      id_rt_used = 1'($urandom_range(0, 1));
      id_branch_taken = ($urandom_range(0, 5) == 0);
      id_mc_start = ($urandom_range(0, 6) == 0);
      exe_rf_wena = 1'($urandom_range(0, 1));
      exe_rf_waddr = 5'($urandom_range(0, 3));
      exe_is_load = 1'($urandom_range(0, 1));
      mem_rf_wena = 1'($urandom_range(0, 1));
      mem_rf_waddr = 5'($urandom_range(0, 3));
      mc_ack = ($urandom_range(0, 3) == 0);
      mc_done = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 199) == 0) do_reset();
      else cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
